spi_ram_burst: RTL and testbench
================================

Name: spi_ram_burst

Overview:
- Parametrised successor to the team's SPI-slave RAM; sits behind the SPI slave and consumes its framed {cmd, payload} words on din/rx_valid.
- Returns read data on dout/tx_valid.
- Adds:
  - generic address/data widths and depth;
  - optional address auto-increment for burst read/write;
  - independent write and read address arming;
  - a protocol-error flag for data commands issued without a loaded address, or for out-of-range addresses.

Parameters:
- DATA_W, 8, payload width and memory word width.
- ADDR_W, 8, address width; must satisfy ADDR_W <= DATA_W (elaboration-time check).
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, 1 = post-increment the address after each data access; 0 = address held.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, DATA_W+2, [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload.
- rx_valid, input, 1, din valid this cycle; one command per cycle.
- dout, output, DATA_W, read data.
- tx_valid, output, 1, dout valid; single-cycle pulse.
- err, output, 1, protocol-error pulse.

Behaviour:
- Command codes (cmd field):
  - 00 WR_ADDR
  - 01 WR_DATA
  - 10 RD_ADDR
  - 11 RD_DATA
- Reset (async assert, sync release): dout=0, tx_valid=0, err=0, wr_ptr=0, rd_ptr=0, wr_armed=0, rd_armed=0. Memory contents are not reset.
- A reset mid-burst disarms both pointers. The next data command then errors until a new ADDR command arrives.
- rx_valid=0: no state change. Next cycle tx_valid=0 and err=0; dout holds its last value.
- WR_ADDR with payload[ADDR_W-1:0] < MEM_DEPTH: wr_ptr <= addr, wr_armed <= 1.
- WR_ADDR with addr >= MEM_DEPTH: err=1 next cycle; wr_ptr and wr_armed unchanged.
- RD_ADDR: same rules as WR_ADDR, applied to rd_ptr and rd_armed.
- WR_DATA with wr_armed=1: mem[wr_ptr] <= payload at this edge.
  - AUTO_INC=1: wr_ptr <= (wr_ptr == MEM_DEPTH-1) ? 0 : wr_ptr+1.
  - AUTO_INC=0: wr_ptr held.
  - wr_armed stays 1.
- WR_DATA with wr_armed=0: no write; err=1 next cycle.
- RD_DATA with rd_armed=1:
  - Next cycle: dout = mem[rd_ptr], tx_valid=1 (latency 1).
  - rd_ptr increments/wraps under the same AUTO_INC rule as wr_ptr.
- RD_DATA with rd_armed=0: err=1 next cycle, tx_valid=0, dout held.
- tx_valid is 1 only in the cycle after an accepted RD_DATA. Any other command or idle cycle gives tx_valid=0 next cycle. Back-to-back RD_DATA gives a continuous tx_valid with new data each cycle.
- Write and read pointers are independent, so interleaved write/read bursts are legal.
- Read-after-write: RD_DATA in the cycle after a WR_DATA to the same address returns the new data (write lands before the read port samples).
- err is a single-cycle pulse, one per offending command; it never coincides with tx_valid=1.

Decomposition:
- Package spi_ram_pkg:
  - typedef enum logic[1:0] cmd_e {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA};
  - field-position localparams for the cmd slice.
- Sub-module spi_ram_mem: a 1-write/1-read synchronous-read array (DATA_W x MEM_DEPTH), no reset. The top keeps the pointers, arm flags and output regs.

Test Plan:
- Reset:
  - rst_n=0 mid-operation → same cycle dout=0, tx_valid=0, err=0.
  - After release, RD_DATA → err=1, tx_valid=0.
- Basic write/read (AUTO_INC=0):
  - WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA → next cycle dout=0xA5, tx_valid=1.
  - Repeat RD_DATA → dout=0xA5 again.
- Burst wrap (AUTO_INC=1, MEM_DEPTH=256):
  - WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33 → mem[FE]=11, mem[FF]=22, mem[00]=33.
  - RD_ADDR 0xFE, then 3x RD_DATA → tx_valid high 3 cycles, dout 11, 22, 33.
- Protocol errors:
  - WR_DATA before any WR_ADDR → err=1, memory unchanged.
  - MEM_DEPTH=200: WR_ADDR 0xC8 → err=1, wr_armed stays 0.
- Interleave:
  - WR_ADDR 5, RD_ADDR 5, WR_DATA 0x3C, RD_DATA → dout=0x3C next cycle (read-after-write).
  - Non-RD_DATA cmds → tx_valid=0 next cycle.
- Idle: rx_valid=0 with din=11 cmd for 4 cycles → tx_valid=0, err=0, pointers unchanged.

Source files
------------

// File: rtl/spi_ram_burst_pkg.sv
// Shared command encoding and field layout for the burst-capable SPI RAM.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    // The cmd field sits directly above the DATA_W-bit payload in each framed word.
    localparam int unsigned CMD_W   = 2;
    localparam int unsigned CMD_OFS = 0;

endpackage

// File: rtl/spi_ram_burst_if.sv
// Framed command input and read-data/error output bundle between the SPI slave and the RAM.
interface spi_ram_burst_if #(
    parameter int unsigned DATA_W = 8
) ();

    logic [DATA_W+1:0] din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              err;

    modport master (output din, output rx_valid, input dout, input tx_valid, input err);
    modport slave  (input din, input rx_valid, output dout, output tx_valid, output err);

endinterface

// File: rtl/spi_ram_burst_mem.sv
// One-write/one-read word array with a registered read port; contents are never reset.
module spi_ram_mem #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Read register only loads on a read, so it holds the last word between reads.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_burst.sv
// Command decoder for the SPI RAM: independent armed write/read pointers with optional
// post-increment, single-cycle read latency and a protocol-error pulse.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter bit          AUTO_INC  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_ram_burst_if.slave  bus
);

    if (ADDR_W > DATA_W) begin : g_bad_addr_w
        $error("spi_ram_burst: ADDR_W must not exceed DATA_W");
    end
    if (MEM_DEPTH > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("spi_ram_burst: MEM_DEPTH must not exceed 2**ADDR_W");
    end

    cmd_e              w_cmd;
    logic [DATA_W-1:0] w_payload;
    logic [ADDR_W-1:0] w_addr;
    logic              w_addr_ok;

    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_d;
    logic [ADDR_W-1:0] r_rd_ptr, w_rd_ptr_d;
    logic              r_wr_armed, w_wr_armed_d;
    logic              r_rd_armed, w_rd_armed_d;
    logic              r_tx_valid, w_tx_valid_d;
    logic              r_err, w_err_d;
    logic              r_rd_seen, w_rd_seen_d;
    logic              w_we, w_re;
    logic [DATA_W-1:0] w_rdata;

    assign w_cmd     = cmd_e'(bus.din[DATA_W+CMD_OFS +: CMD_W]);
    assign w_payload = bus.din[DATA_W-1:0];
    assign w_addr    = w_payload[ADDR_W-1:0];
    assign w_addr_ok = 32'(w_addr) < MEM_DEPTH;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
        if (!AUTO_INC) return ptr;
        return (ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr + ADDR_W'(1);
    endfunction

    always_comb begin
        w_wr_ptr_d   = r_wr_ptr;
        w_rd_ptr_d   = r_rd_ptr;
        w_wr_armed_d = r_wr_armed;
        w_rd_armed_d = r_rd_armed;
        w_rd_seen_d  = r_rd_seen;
        w_tx_valid_d = 1'b0;
        w_err_d      = 1'b0;
        w_we         = 1'b0;
        w_re         = 1'b0;
        if (bus.rx_valid) begin
            unique case (w_cmd)
                WR_ADDR: begin
                    if (w_addr_ok) begin
                        w_wr_ptr_d   = w_addr;
                        w_wr_armed_d = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                WR_DATA: begin
                    if (r_wr_armed) begin
                        w_we       = 1'b1;
                        w_wr_ptr_d = next_ptr(r_wr_ptr);
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                RD_ADDR: begin
                    if (w_addr_ok) begin
                        w_rd_ptr_d   = w_addr;
                        w_rd_armed_d = 1'b1;
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                RD_DATA: begin
                    if (r_rd_armed) begin
                        w_re         = 1'b1;
                        w_tx_valid_d = 1'b1;
                        w_rd_seen_d  = 1'b1;
                        w_rd_ptr_d   = next_ptr(r_rd_ptr);
                    end else begin
                        w_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_tx_valid <= 1'b0;
            r_err      <= 1'b0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_wr_armed <= w_wr_armed_d;
            r_rd_armed <= w_rd_armed_d;
            r_tx_valid <= w_tx_valid_d;
            r_err      <= w_err_d;
            r_rd_seen  <= w_rd_seen_d;
        end
    end

    spi_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_payload),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // The array's read register has no reset, so dout reads as zero until a read since reset.
    assign bus.dout     = r_rd_seen ? w_rdata : '0;
    assign bus.tx_valid = r_tx_valid;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: three configurations (held address, auto-increment, depth 200) share stimulus.
module tb_spi_ram_burst;
    import spi_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] g_dout [3];
    logic       g_tx   [3];
    logic       g_err  [3];

    always #5 clk = ~clk;

    spi_ram_burst_if #(.DATA_W(8)) if0 ();
    spi_ram_burst_if #(.DATA_W(8)) if1 ();
    spi_ram_burst_if #(.DATA_W(8)) if2 ();

    assign if0.din = din;  assign if0.rx_valid = rx_valid;
    assign if1.din = din;  assign if1.rx_valid = rx_valid;
    assign if2.din = din;  assign if2.rx_valid = rx_valid;
    assign g_dout[0] = if0.dout; assign g_tx[0] = if0.tx_valid; assign g_err[0] = if0.err;
    assign g_dout[1] = if1.dout; assign g_tx[1] = if1.tx_valid; assign g_err[1] = if1.err;
    assign g_dout[2] = if2.dout; assign g_tx[2] = if2.tx_valid; assign g_err[2] = if2.err;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b0)) u_inc0 (
        .clk (clk), .rst_n (rst_n), .bus (if0)
    );
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)) u_inc1 (
        .clk (clk), .rst_n (rst_n), .bus (if1)
    );
    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1'b1)) u_d200 (
        .clk (clk), .rst_n (rst_n), .bus (if2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int i, input logic [7:0] d_e,
                           input logic tx_e, input logic err_e);
        check_eq({tag, ".dout"}, 32'(g_dout[i]), 32'(d_e));
        check_eq({tag, ".tx"},   32'(g_tx[i]),   32'(tx_e));
        check_eq({tag, ".err"},  32'(g_err[i]),  32'(err_e));
    endtask

    task automatic chk_flags(input string tag, input int i, input logic tx_e, input logic err_e);
        check_eq({tag, ".tx"},  32'(g_tx[i]),  32'(tx_e));
        check_eq({tag, ".err"}, 32'(g_err[i]), 32'(err_e));
    endtask

    task automatic send(input cmd_e cmd, input logic [7:0] pay);
        din      = {cmd, pay};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = '0;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Seed mem[0] in every instance, read it back, then reset mid-operation.
        send(WR_ADDR, 8'h00);
        send(WR_DATA, 8'h5A);
        send(RD_ADDR, 8'h00);
        send(RD_DATA, 8'h00);
        chk_out("seed_rd", 0, 8'h5A, 1'b1, 1'b0);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_out("async_rst", 0, 8'h00, 1'b0, 1'b0);
        chk_out("async_rst1", 1, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(RD_DATA, 8'h00);
        chk_out("rd_unarmed", 0, 8'h00, 1'b0, 1'b1);
        send(WR_DATA, 8'h77);
        chk_flags("wr_unarmed", 0, 1'b0, 1'b1);
        send(RD_ADDR, 8'h00);
        chk_flags("rd_addr0", 0, 1'b0, 1'b0);
        send(RD_DATA, 8'h00);
        chk_out("mem_untouched", 0, 8'h5A, 1'b1, 1'b0);

        // Basic write/read with held address.
        send(WR_ADDR, 8'h10);
        chk_flags("wr_addr10", 0, 1'b0, 1'b0);
        send(WR_DATA, 8'hA5);
        send(RD_ADDR, 8'h10);
        send(RD_DATA, 8'h00);
        chk_out("basic_rd", 0, 8'hA5, 1'b1, 1'b0);
        send(RD_DATA, 8'h00);
        chk_out("basic_rd2", 0, 8'hA5, 1'b1, 1'b0);

        // Burst across the 0xFF -> 0x00 wrap; 0xFE is out of range for the depth-200 copy.
        send(WR_ADDR, 8'hFE);
        chk_flags("wr_addr_fe", 1, 1'b0, 1'b0);
        chk_flags("d200_fe_oor", 2, 1'b0, 1'b1);
        send(WR_DATA, 8'h11);
        send(WR_DATA, 8'h22);
        send(WR_DATA, 8'h33);
        send(RD_ADDR, 8'hFE);
        send(RD_DATA, 8'h00);
        chk_out("burst0", 1, 8'h11, 1'b1, 1'b0);
        send(RD_DATA, 8'h00);
        chk_out("burst1", 1, 8'h22, 1'b1, 1'b0);
        send(RD_DATA, 8'h00);
        chk_out("burst2", 1, 8'h33, 1'b1, 1'b0);

        // Depth-200 boundary: 0xC8 rejected, 0xC7 accepted and wraps to 0.
        pulse_reset();
        send(WR_ADDR, 8'hC8);
        chk_flags("d200_c8", 2, 1'b0, 1'b1);
        chk_flags("d256_c8", 1, 1'b0, 1'b0);
        send(WR_DATA, 8'h99);
        chk_flags("d200_still_unarmed", 2, 1'b0, 1'b1);
        send(WR_ADDR, 8'hC7);
        chk_flags("d200_c7", 2, 1'b0, 1'b0);
        send(WR_DATA, 8'h44);
        send(WR_DATA, 8'h55);
        send(RD_ADDR, 8'hC7);
        send(RD_DATA, 8'h00);
        chk_out("d200_rd_c7", 2, 8'h44, 1'b1, 1'b0);
        send(RD_DATA, 8'h00);
        chk_out("d200_wrap", 2, 8'h55, 1'b1, 1'b0);

        // Interleaved pointers with read-after-write.
        send(WR_ADDR, 8'h05);
        send(RD_ADDR, 8'h05);
        send(WR_DATA, 8'h3C);
        send(RD_DATA, 8'h00);
        chk_out("raw_inc1", 1, 8'h3C, 1'b1, 1'b0);
        chk_out("raw_inc0", 0, 8'h3C, 1'b1, 1'b0);
        send(WR_ADDR, 8'h06);
        chk_out("non_rd_cmd", 1, 8'h3C, 1'b0, 1'b0);

        // Idle with an RD_DATA code on din must not touch anything.
        din      = {RD_DATA, 8'h00};
        rx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("idle%0d", k), 1, 8'h3C, 1'b0, 1'b0);
        end
        send(WR_DATA, 8'h66);
        send(RD_DATA, 8'h00);
        chk_out("ptrs_after_idle", 1, 8'h66, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
